// File: rtl/lane_block_scheduler.sv
// Spawns, moves, judges and scores falling blocks, with two slots per lane across four lanes.
// Updates take one cycle and pulses are registered. There is no backpressure: spawns into a full lane are dropped and overflow latches.
module lane_block_scheduler #(
    parameter logic [9:0] SPAWN_H    = 10'd120,
    parameter logic [9:0] BOTTOM_H   = 10'd720,
    parameter logic [9:0] HIT_LO     = 10'd600,
    parameter logic [9:0] HIT_HI     = 10'd719,
    parameter logic [3:0] MISS_LIMIT = 4'd8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        restart,
    input  logic        stop_or_endgame,
    input  logic [1:0]  level,
    input  logic [6:0]  beat_cnt,
    input  logic [3:0]  spawn_mask,
    input  logic        tick,
    input  logic [3:0]  hit_lane,
    output logic [79:0] block_h,
    output logic [7:0]  block_vld,
    output logic        hit_pulse,
    output logic        miss_pulse,
    output logic [9:0]  score,
    output logic        overflow,
    output logic        game_over
);

    localparam logic [9:0] SCORE_MAX = 10'd999;

    typedef enum logic [1:0] {S_RUN, S_HOLD, S_OVER} state_t;

    state_t      state_q, state_d;
    logic [9:0]  h_q [0:7];
    logic [9:0]  h_d [0:7];
    logic [7:0]  vld_q, vld_d;
    logic [9:0]  score_q, score_d;
    logic [3:0]  miss_cnt_q, miss_cnt_d;
    logic        overflow_q, overflow_d;
    logic        hit_pulse_q, hit_pulse_d;
    logic        miss_pulse_q, miss_pulse_d;
    logic [6:0]  prev_beat_q, prev_beat_d;

    logic        active;
    logic        beat_add;
    logic [2:0]  n_hit, n_miss;
    logic        cand0, cand1;
    logic [10:0] step_sum;
    logic [10:0] score_sum;
    logic [4:0]  miss_sum;

    always_comb begin
        state_d      = state_q;
        vld_d        = vld_q;
        score_d      = score_q;
        miss_cnt_d   = miss_cnt_q;
        overflow_d   = overflow_q;
        prev_beat_d  = beat_cnt;
        n_hit        = 3'd0;
        n_miss       = 3'd0;
        cand0        = 1'b0;
        cand1        = 1'b0;
        step_sum     = 11'd0;
        score_sum    = 11'd0;
        miss_sum     = 5'd0;
        for (int k = 0; k < 8; k++) begin
            h_d[k] = h_q[k];
        end

        active   = (state_q == S_RUN) && !stop_or_endgame;
        beat_add = (beat_cnt > prev_beat_q);

        if (active) begin
            for (int l = 0; l < 4; l++) begin
                for (int s = 0; s < 2; s++) begin
                    if (vld_q[2*l+s] && (h_q[2*l+s] >= BOTTOM_H)) begin
                        vld_d[2*l+s] = 1'b0;
                        n_miss       = n_miss + 3'd1;
                    end
                end

                // Deepest block in the window wins; equal heights favour slot 0.
                cand0 = vld_d[2*l]   && (h_q[2*l]   >= HIT_LO) && (h_q[2*l]   <= HIT_HI);
                cand1 = vld_d[2*l+1] && (h_q[2*l+1] >= HIT_LO) && (h_q[2*l+1] <= HIT_HI);
                if (hit_lane[l]) begin
                    if (cand1 && (!cand0 || (h_q[2*l+1] > h_q[2*l]))) begin
                        vld_d[2*l+1] = 1'b0;
                        n_hit        = n_hit + 3'd1;
                    end else if (cand0) begin
                        vld_d[2*l] = 1'b0;
                        n_hit      = n_hit + 3'd1;
                    end
                end

                if (tick) begin
                    for (int s = 0; s < 2; s++) begin
                        if (vld_d[2*l+s]) begin
                            step_sum    = {1'b0, h_q[2*l+s]} + {9'd0, level} + 11'd1;
                            h_d[2*l+s]  = (step_sum > {1'b0, BOTTOM_H}) ? BOTTOM_H : step_sum[9:0];
                        end
                    end
                end

                // Spawn last so a fresh block skips this tick and can reuse a slot freed above.
                if (beat_add && spawn_mask[l]) begin
                    if (!vld_d[2*l]) begin
                        vld_d[2*l] = 1'b1;
                        h_d[2*l]   = SPAWN_H;
                    end else if (!vld_d[2*l+1]) begin
                        vld_d[2*l+1] = 1'b1;
                        h_d[2*l+1]   = SPAWN_H;
                    end else begin
                        overflow_d = 1'b1;
                    end
                end
            end
        end

        score_sum  = {1'b0, score_q} + {8'd0, n_hit};
        score_d    = (score_sum > {1'b0, SCORE_MAX}) ? SCORE_MAX : score_sum[9:0];
        miss_sum   = {1'b0, miss_cnt_q} + {2'd0, n_miss};
        miss_cnt_d = (miss_sum > {1'b0, MISS_LIMIT}) ? MISS_LIMIT : miss_sum[3:0];

        hit_pulse_d  = (n_hit != 3'd0);
        miss_pulse_d = (n_miss != 3'd0);

        case (state_q)
            S_RUN: begin
                if (miss_cnt_d >= MISS_LIMIT) begin
                    state_d = S_OVER;
                end else if (stop_or_endgame) begin
                    state_d = S_HOLD;
                end
            end
            S_HOLD: begin
                if (!stop_or_endgame) begin
                    state_d = S_RUN;
                end
            end
            default: state_d = S_OVER;
        endcase

        if (restart) begin
            state_d      = S_RUN;
            vld_d        = 8'd0;
            score_d      = 10'd0;
            miss_cnt_d   = 4'd0;
            overflow_d   = 1'b0;
            hit_pulse_d  = 1'b0;
            miss_pulse_d = 1'b0;
            prev_beat_d  = 7'd0;
            for (int k = 0; k < 8; k++) begin
                h_d[k] = 10'd0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_RUN;
            vld_q        <= 8'd0;
            score_q      <= 10'd0;
            miss_cnt_q   <= 4'd0;
            overflow_q   <= 1'b0;
            hit_pulse_q  <= 1'b0;
            miss_pulse_q <= 1'b0;
            prev_beat_q  <= 7'd0;
            for (int k = 0; k < 8; k++) begin
                h_q[k] <= 10'd0;
            end
        end else begin
            state_q      <= state_d;
            vld_q        <= vld_d;
            score_q      <= score_d;
            miss_cnt_q   <= miss_cnt_d;
            overflow_q   <= overflow_d;
            hit_pulse_q  <= hit_pulse_d;
            miss_pulse_q <= miss_pulse_d;
            prev_beat_q  <= prev_beat_d;
            for (int k = 0; k < 8; k++) begin
                h_q[k] <= h_d[k];
            end
        end
    end

    for (genvar g = 0; g < 8; g++) begin : g_flat
        assign block_h[g*10 +: 10] = h_q[g];
    end

    assign block_vld  = vld_q;
    assign hit_pulse  = hit_pulse_q;
    assign miss_pulse = miss_pulse_q;
    assign score      = score_q;
    assign overflow   = overflow_q;
    assign game_over  = (state_q == S_OVER);

endmodule

// File: tb/tb_lane_block_scheduler.sv
// Directed bench for lane_block_scheduler with hand-computed expectations.
module tb_lane_block_scheduler;

    logic        clk = 1'b0;
    logic        rst;
    logic        restart;
    logic        stop_or_endgame;
    logic [1:0]  level;
    logic [6:0]  beat_cnt;
    logic [3:0]  spawn_mask;
    logic        tick;
    logic [3:0]  hit_lane;
    logic [79:0] block_h;
    logic [7:0]  block_vld;
    logic        hit_pulse;
    logic        miss_pulse;
    logic [9:0]  score;
    logic        overflow;
    logic        game_over;

    int n_cmp = 0;
    int n_err = 0;

    lane_block_scheduler dut (
        .clk             (clk),
        .rst             (rst),
        .restart         (restart),
        .stop_or_endgame (stop_or_endgame),
        .level           (level),
        .beat_cnt        (beat_cnt),
        .spawn_mask      (spawn_mask),
        .tick            (tick),
        .hit_lane        (hit_lane),
        .block_h         (block_h),
        .block_vld       (block_vld),
        .hit_pulse       (hit_pulse),
        .miss_pulse      (miss_pulse),
        .score           (score),
        .overflow        (overflow),
        .game_over       (game_over)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        tick = 1'b1;
        repeat (n) cyc();
        tick = 1'b0;
    endtask

    function automatic logic [9:0] slot_h(input int k);
        return block_h[k*10 +: 10];
    endfunction

    task automatic check(input string tag, input logic [79:0] obs, input logic [79:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1; restart = 1'b0; stop_or_endgame = 1'b0; level = 2'd0;
        beat_cnt = 7'd0; spawn_mask = 4'd0; tick = 1'b0; hit_lane = 4'd0;
        #12 rst = 1'b0;

        check("rst_vld", block_vld, 0);
        check("rst_h", block_h, 0);
        check("rst_score", score, 0);
        check("rst_ovf", overflow, 0);
        check("rst_over", game_over, 0);
        check("rst_pulses", {hit_pulse, miss_pulse}, 0);

        // spawn on a rising beat
        beat_cnt = 7'd10; cyc();
        beat_cnt = 7'd11; spawn_mask = 4'b0001; cyc();
        spawn_mask = 4'd0;
        check("spawn_vld", block_vld, 8'h01);
        check("spawn_h", slot_h(0), 120);

        // fall at level 3 to the bottom, then expire
        level = 2'd3;
        ticks(149);
        check("fall_716", slot_h(0), 716);
        ticks(1);
        check("fall_720", slot_h(0), 720);
        check("fall_vld", block_vld, 8'h01);
        check("fall_nomiss", miss_pulse, 0);
        cyc();
        check("expire_vld", block_vld, 8'h00);
        check("expire_pulse", miss_pulse, 1);
        cyc();
        check("expire_pulse_one", miss_pulse, 0);

        // two lane-2 blocks at 650 / 610, hit picks the deeper one
        beat_cnt = 7'd12; spawn_mask = 4'b0100; cyc();
        spawn_mask = 4'd0;
        level = 2'd1;
        ticks(20);
        beat_cnt = 7'd13; spawn_mask = 4'b0100; cyc();
        spawn_mask = 4'd0;
        ticks(245);
        check("l2_s0_h", slot_h(4), 650);
        check("l2_s1_h", slot_h(5), 610);
        hit_lane = 4'b0100; cyc(); hit_lane = 4'd0;
        check("hit_vld", block_vld, 8'h20);
        check("hit_left_h", slot_h(5), 610);
        check("hit_score", score, 1);
        check("hit_pulse", hit_pulse, 1);
        cyc();
        check("hit_pulse_one", hit_pulse, 0);
        hit_lane = 4'b0100; cyc(); hit_lane = 4'd0;
        check("hit2_vld", block_vld, 8'h00);
        check("hit2_score", score, 2);

        // press with a block outside the window is ignored
        beat_cnt = 7'd14; spawn_mask = 4'b1000; cyc();
        spawn_mask = 4'd0;
        ticks(90);
        check("l3_h300", slot_h(6), 300);
        hit_lane = 4'b1000; cyc(); hit_lane = 4'd0;
        check("nohit_vld", block_vld, 8'h40);
        check("nohit_h", slot_h(6), 300);
        check("nohit_score", score, 2);
        check("nohit_pulse", hit_pulse, 0);

        // lane 1 full -> third spawn dropped
        spawn_mask = 4'b0010;
        beat_cnt = 7'd15; cyc();
        beat_cnt = 7'd16; cyc();
        check("full_ovf0", overflow, 0);
        beat_cnt = 7'd17; cyc();
        spawn_mask = 4'd0;
        check("full_ovf1", overflow, 1);
        check("full_vld", block_vld, 8'h4C);
        check("full_h", {slot_h(3), slot_h(2)}, {10'd120, 10'd120});

        // drain 3 misses (total 4), then 4 simultaneous misses -> game over
        level = 2'd3;
        ticks(160);
        check("drain_vld", block_vld, 8'h00);
        check("drain_notover", game_over, 0);
        beat_cnt = 7'd18; spawn_mask = 4'b1111; cyc();
        spawn_mask = 4'd0;
        check("quad_vld", block_vld, 8'h55);
        ticks(150);
        check("quad_h", {slot_h(6), slot_h(4), slot_h(2), slot_h(0)},
              {10'd720, 10'd720, 10'd720, 10'd720});
        cyc();
        check("quad_expire", block_vld, 8'h00);
        check("quad_pulse", miss_pulse, 1);
        cyc();
        check("over_flag", game_over, 1);
        check("over_pulse_one", miss_pulse, 0);
        beat_cnt = 7'd19; spawn_mask = 4'b0001; tick = 1'b1;
        repeat (5) cyc();
        spawn_mask = 4'd0; tick = 1'b0;
        check("over_frozen_vld", block_vld, 8'h00);
        check("over_still", game_over, 1);
        check("over_score", score, 2);

        // restart clears everything
        beat_cnt = 7'd0; restart = 1'b1; cyc(); restart = 1'b0;
        check("rs_vld", block_vld, 0);
        check("rs_h", block_h, 0);
        check("rs_score", score, 0);
        check("rs_ovf", overflow, 0);
        check("rs_over", game_over, 0);

        // full lane where one slot expires the same cycle a spawn arrives
        beat_cnt = 7'd2; spawn_mask = 4'b0010; cyc();
        spawn_mask = 4'd0;
        ticks(1);
        beat_cnt = 7'd3; spawn_mask = 4'b0010; cyc();
        spawn_mask = 4'd0;
        ticks(149);
        check("exsp_pre", {slot_h(3), slot_h(2)}, {10'd716, 10'd720});
        beat_cnt = 7'd4; spawn_mask = 4'b0010; cyc();
        spawn_mask = 4'd0;
        check("exsp_vld", block_vld, 8'h0C);
        check("exsp_h", {slot_h(3), slot_h(2)}, {10'd716, 10'd120});
        check("exsp_ovf", overflow, 0);
        check("exsp_miss", miss_pulse, 1);

        // pause freezes motion and spawn
        stop_or_endgame = 1'b1; beat_cnt = 7'd5; spawn_mask = 4'b0001; tick = 1'b1;
        repeat (20) cyc();
        tick = 1'b0; spawn_mask = 4'd0; stop_or_endgame = 1'b0;
        cyc(); cyc();
        check("hold_vld", block_vld, 8'h0C);
        check("hold_h", {slot_h(3), slot_h(2)}, {10'd716, 10'd120});
        check("hold_over", game_over, 0);

        // asynchronous reset between clock edges
        rst = 1'b1;
        #2;
        check("arst_vld", block_vld, 0);
        check("arst_h", block_h, 0);
        #5 rst = 1'b0;
        cyc();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
